man_drawer: RTL

- Downstream consumer of the running man's vertical position (7-bit y, updated once per game tick by the y-position block).
- On every update tick it erases the man's sprite box at the previously drawn y, then draws it at the new y.
- Emits one pixel per clock to the VGA adapter's plot/x/y/colour interface.
- Man column is fixed; only y moves.

---
 rtl/man_drawer_if.sv | 24 ++
 rtl/man_drawer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/man_drawer_if.sv
// Pixel bus between the running-man drawer and its neighbours: tick/y inputs in,
// VGA plot stream and status pulses out.
interface man_drawer_if;
  logic       update;
  logic [6:0] y_in;
  logic       man_style;
  logic       plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       busy;
  logic       done;
  logic       missed;

  modport master (
    output update, y_in, man_style,
    input  plot, vga_x, vga_y, colour, busy, done, missed
  );

  modport slave (
    input  update, y_in, man_style,
    output plot, vga_x, vga_y, colour, busy, done, missed
  );
endinterface

// File: rtl/man_drawer.sv
// Erases the man's sprite box at its previous row and redraws it at the new row,
// one pixel per clock, on every rising edge of the game tick.
module man_drawer #(
  parameter logic [7:0] X_POS      = 8'd20,
  parameter int         MAN_W      = 8,
  parameter int         MAN_H      = 12,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter logic [2:0] MAN_COLOUR = 3'b110
) (
  input  logic         clk,
  input  logic         reset,
  man_drawer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [3:0] X_LAST  = 4'(MAN_W - 1);
  localparam logic [3:0] Y_LAST  = 4'(MAN_H - 1);
  localparam logic [7:0] ROW_MAX = 8'd119;

  state_e      state_q, state_d;
  logic [3:0]  cx_q, cx_d;
  logic [3:0]  cy_q, cy_d;
  logic [6:0]  new_y_q, new_y_d;
  logic [6:0]  old_y_q, old_y_d;
  logic        old_valid_q, old_valid_d;
  logic        vis_q, vis_d;
  logic        update_q, update_d;
  logic        plot_q, plot_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  colour_q, colour_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        missed_q, missed_d;

  logic        start_s;
  logic        emit_s;
  logic        erase_s;
  logic        vis_s;
  logic [6:0]  base_y_s;
  logic [3:0]  sx_s;
  logic [3:0]  sy_s;
  logic [7:0]  row_s;
  logic        last_s;

  // The first pixel is issued straight from IDLE so plot rises the cycle after start.
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    new_y_d     = new_y_q;
    old_y_d     = old_y_q;
    old_valid_d = old_valid_q;
    vis_d       = vis_q;
    update_d    = bus.update;
    plot_d      = 1'b0;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    colour_d    = colour_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    start_s     = bus.update & ~update_q;
    missed_d    = start_s & (state_q != IDLE);
    emit_s      = 1'b0;
    erase_s     = 1'b0;
    vis_s       = vis_q;
    base_y_s    = new_y_q;
    sx_s        = cx_q;
    sy_s        = cy_q;

    case (state_q)
      IDLE: begin
        if (start_s) begin
          new_y_d = bus.y_in;
          vis_d   = bus.man_style;
          vis_s   = bus.man_style;
          sx_s    = 4'd0;
          sy_s    = 4'd0;
          cx_d    = 4'd0;
          cy_d    = 4'd0;
          if (old_valid_q) begin
            emit_s   = 1'b1;
            erase_s  = 1'b1;
            base_y_s = old_y_q;
          end else if (bus.man_style) begin
            emit_s   = 1'b1;
            base_y_s = bus.y_in;
          end else begin
            state_d  = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ERASE: begin
        emit_s   = 1'b1;
        erase_s  = 1'b1;
        base_y_s = old_y_q;
      end
      DRAW: begin
        emit_s = 1'b1;
      end
      FIN: begin
        done_d      = 1'b1;
        old_y_d     = new_y_q;
        old_valid_d = vis_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    row_s  = {1'b0, base_y_s} + {4'b0000, sy_s};
    last_s = (sx_s == X_LAST) && (sy_s == Y_LAST);

    if (emit_s) begin
      // Rows past the bottom of the screen still scan, so frame length never varies.
      plot_d   = (row_s <= ROW_MAX);
      vga_x_d  = X_POS + {4'b0000, sx_s};
      vga_y_d  = row_s[6:0];
      colour_d = erase_s ? BG_COLOUR : MAN_COLOUR;
      busy_d   = 1'b1;
      if (last_s) begin
        cx_d    = 4'd0;
        cy_d    = 4'd0;
        state_d = (erase_s && vis_s) ? DRAW : FIN;
      end else begin
        state_d = erase_s ? ERASE : DRAW;
        if (sx_s == X_LAST) begin
          cx_d = 4'd0;
          cy_d = sy_s + 4'd1;
        end else begin
          cx_d = sx_s + 4'd1;
          cy_d = sy_s;
        end
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // State, scan counters and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cx_q        <= 4'd0;
      cy_q        <= 4'd0;
      new_y_q     <= 7'd0;
      old_y_q     <= 7'd0;
      old_valid_q <= 1'b0;
      vis_q       <= 1'b0;
      update_q    <= 1'b0;
      plot_q      <= 1'b0;
      vga_x_q     <= 8'd0;
      vga_y_q     <= 7'd0;
      colour_q    <= 3'b000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      new_y_q     <= new_y_d;
      old_y_q     <= old_y_d;
      old_valid_q <= old_valid_d;
      vis_q       <= vis_d;
      update_q    <= update_d;
      plot_q      <= plot_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      colour_q    <= colour_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
    end
  end

  assign bus.plot   = plot_q;
  assign bus.vga_x  = vga_x_q;
  assign bus.vga_y  = vga_y_q;
  assign bus.colour = colour_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.missed = missed_q;

endmodule
